mmul_mac: RTL and testbench



---
 rtl/mmul_mac.sv | 189 ++++++++++++++++++
 tb/tb_mmul_mac.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mmul_mac.sv
// Mode-selectable matrix engine: A*B, A+B or A.*B over flattened unsigned matrices,
// one term per cycle through a shared multiply-accumulate path with optional saturation.
module mmul_mac #(
  parameter int unsigned M         = 3,
  parameter int unsigned N         = 3,
  parameter int unsigned K         = 3,
  parameter int unsigned L         = 3,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 16,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [M*N*WIDTH-1:0]       mat_a,
  input  logic [K*L*WIDTH-1:0]       mat_b,
  output logic [M*L*ACC_WIDTH-1:0]   result,
  output logic                       busy,
  output logic                       done,
  output logic                       invalid,
  output logic                       overflow
);

  localparam int unsigned DimMax = (M > N) ? ((M > L) ? M : L) : ((N > L) ? N : L);
  localparam int unsigned CW     = (DimMax > 1) ? $clog2(DimMax) : 1;
  // Wide enough to hold a full product plus a wrapped accumulator without losing the carry
  localparam int unsigned SW     = ((2 * WIDTH > ACC_WIDTH) ? 2 * WIDTH : ACC_WIDTH) + 1;

  localparam logic [1:0] ModeMul  = 2'b00;
  localparam logic [1:0] ModeAdd  = 2'b01;
  localparam logic [1:0] ModeEmul = 2'b10;

  typedef enum logic [2:0] {StIdle, StCheck, StCompute, StWrite, StDone} state_e;

  state_e                     state_q, state_d;
  logic [M*N*WIDTH-1:0]       a_q, a_d;
  logic [K*L*WIDTH-1:0]       b_q, b_d;
  logic [1:0]                 mode_q, mode_d;
  logic [M*L*ACC_WIDTH-1:0]   result_q, result_d;
  logic                       invalid_q, invalid_d;
  logic                       overflow_q, overflow_d;
  logic                       ovf_pend_q, ovf_pend_d;
  // Top bit is the sticky overflow of the element being accumulated
  logic [ACC_WIDTH:0]         acc_q, acc_d;
  logic [CW-1:0]              i_q, i_d, j_q, j_d, k_q, k_d;

  logic                       valid;
  logic                       last_i, last_j, last_k;
  int unsigned                a_idx, b_idx, r_idx;
  logic [WIDTH-1:0]           a_el, b_el;
  logic [SW-1:0]              term, sum;
  logic                       elem_ovf;
  logic [ACC_WIDTH-1:0]       elem_val;

  always_comb begin
    valid = 1'b0;
    unique case (mode_q)
      ModeMul:           valid = (N == K);
      ModeAdd, ModeEmul: valid = (M == K) && (N == L);
      default:           valid = 1'b0;
    endcase
  end

  always_comb begin
    last_i = (i_q == CW'(M - 1));
    last_j = (j_q == CW'(L - 1));
    last_k = (mode_q == ModeMul) ? (k_q == CW'(N - 1)) : 1'b1;
    if (mode_q == ModeMul) begin
      a_idx = 32'(i_q) * N + 32'(k_q);
      b_idx = 32'(k_q) * L + 32'(j_q);
    end else begin
      a_idx = 32'(i_q) * N + 32'(j_q);
      b_idx = 32'(i_q) * L + 32'(j_q);
    end
    r_idx = 32'(i_q) * L + 32'(j_q);
    a_el  = a_q[a_idx*WIDTH +: WIDTH];
    b_el  = b_q[b_idx*WIDTH +: WIDTH];
    if (mode_q == ModeAdd) term = SW'(a_el) + SW'(b_el);
    else                   term = SW'(a_el) * SW'(b_el);
    sum      = SW'(acc_q[ACC_WIDTH-1:0]) + term;
    elem_ovf = acc_q[ACC_WIDTH] | (|sum[SW-1:ACC_WIDTH]);
    elem_val = (SATURATE && elem_ovf) ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    result_d   = result_q;
    invalid_d  = invalid_q;
    overflow_d = overflow_q;
    ovf_pend_d = ovf_pend_q;
    acc_d      = acc_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = mat_a;
          b_d     = mat_b;
          mode_d  = mode;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (valid) begin
          result_d   = '0;
          overflow_d = 1'b0;
          invalid_d  = 1'b0;
          ovf_pend_d = 1'b0;
          acc_d      = '0;
          i_d        = '0;
          j_d        = '0;
          k_d        = '0;
          state_d    = StCompute;
        end else begin
          invalid_d = 1'b1;
          state_d   = StDone;
        end
      end
      StCompute: begin
        acc_d = {elem_ovf, elem_val};
        if (last_k) begin
          result_d[r_idx*ACC_WIDTH +: ACC_WIDTH] = elem_val;
          ovf_pend_d = ovf_pend_q | elem_ovf;
          acc_d      = '0;
          k_d        = '0;
          if (last_j) begin
            j_d = '0;
            i_d = i_q + 1'b1;
            if (last_i) state_d = StWrite;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StWrite: begin
        overflow_d = ovf_pend_q;
        state_d    = StDone;
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= '0;
      result_q   <= '0;
      invalid_q  <= 1'b0;
      overflow_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      acc_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      result_q   <= result_d;
      invalid_q  <= invalid_d;
      overflow_q <= overflow_d;
      ovf_pend_q <= ovf_pend_d;
      acc_q      <= acc_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
    end
  end

  assign result   = result_q;
  assign busy     = (state_q == StCompute) || (state_q == StWrite);
  assign done     = (state_q == StDone);
  assign invalid  = invalid_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mmul_mac.sv
// Directed bench for mmul_mac: 2x2 wrap/saturate variants plus a dimension-mismatched instance.
module tb_mmul_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] mat_a, mat_b;

  logic [63:0] res_a, res_i;
  logic [31:0] res_s, res_w;
  logic busy_a, done_a, inv_a, ovf_a;
  logic busy_s, done_s, inv_s, ovf_s;
  logic busy_w, done_w, inv_w, ovf_w;
  logic busy_i, done_i, inv_i, ovf_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmul_mac #(.M(2), .N(2), .K(2), .L(2), .WIDTH(8), .ACC_WIDTH(16), .SATURATE(1'b0)) u_a (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .mat_a(mat_a), .mat_b(mat_b),
    .result(res_a), .busy(busy_a), .done(done_a), .invalid(inv_a), .overflow(ovf_a)
  );

  mmul_mac #(.M(2), .N(2), .K(2), .L(2), .WIDTH(8), .ACC_WIDTH(8), .SATURATE(1'b1)) u_s (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .mat_a(mat_a), .mat_b(mat_b),
    .result(res_s), .busy(busy_s), .done(done_s), .invalid(inv_s), .overflow(ovf_s)
  );

  mmul_mac #(.M(2), .N(2), .K(2), .L(2), .WIDTH(8), .ACC_WIDTH(8), .SATURATE(1'b0)) u_w (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .mat_a(mat_a), .mat_b(mat_b),
    .result(res_w), .busy(busy_w), .done(done_w), .invalid(inv_w), .overflow(ovf_w)
  );

  mmul_mac #(.M(2), .N(3), .K(2), .L(2), .WIDTH(8), .ACC_WIDTH(16), .SATURATE(1'b0)) u_i (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .mat_a({mat_a[15:0], mat_a}),
    .mat_b(mat_b), .result(res_i), .busy(busy_i), .done(done_i), .invalid(inv_i),
    .overflow(ovf_i)
  );

  typedef struct {
    logic [1:0]  md;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          hold;
    logic [63:0] res;
    logic [31:0] res_s;
    logic [31:0] res_w;
    logic        inv;
    logic        ovf;
    logic        ovf_sw;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] pk8(input int e0, input int e1, input int e2, input int e3);
    return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
  endfunction

  function automatic logic [63:0] pk16(input int e0, input int e1, input int e2, input int e3);
    return {e3[15:0], e2[15:0], e1[15:0], e0[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int n;
    int ni;
    @(negedge clk);
    mode  = v.md;
    mat_a = v.a;
    mat_b = v.b;
    start = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the run must use the captured copies
    mode  = 2'b11;
    mat_a = 32'hDEAD_BEEF;
    mat_b = 32'h1234_5678;
    n  = 0;
    ni = 0;
    while (!done_a && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (done_i && ni == 0) ni = n;
      if (n == 2 && !v.inv) check("busy_in_compute", 64'(busy_a), 64'd1);
      check("busy_done_excl", 64'(busy_a & done_a), 64'd0);
    end
    check("latency", 64'(n), 64'(v.lat));
    check("latency_invalid_inst", 64'(ni), 64'd1);
    check("result_acc16", res_a, v.res);
    check("result_sat8", 64'(res_s), 64'(v.res_s));
    check("result_wrap8", 64'(res_w), 64'(v.res_w));
    check("invalid_flags", 64'({inv_a, inv_s, inv_w, inv_i}), 64'({v.inv, v.inv, v.inv, 1'b1}));
    check("overflow_flags", 64'({ovf_a, ovf_s, ovf_w}), 64'({v.ovf, v.ovf_sw, v.ovf_sw}));
    check("result_invalid_inst", res_i, 64'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk);
      #1;
      check("done_held", 64'({done_a, busy_a, done_i}), 64'(3'b101));
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_fall", 64'({done_a, done_s, done_w, done_i}), 64'd0);
  endtask

  initial begin
    logic [31:0] a0, b0, ff;
    a0 = pk8(1, 2, 3, 4);
    b0 = pk8(5, 6, 7, 8);
    ff = 32'hFFFF_FFFF;
    vecs[0] = '{2'b00, a0, b0, 10, 5, pk16(19, 22, 43, 50), pk8(19, 22, 43, 50),
                pk8(19, 22, 43, 50), 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b01, a0, b0, 6, 1, pk16(6, 8, 10, 12), pk8(6, 8, 10, 12),
                pk8(6, 8, 10, 12), 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b10, a0, b0, 6, 1, pk16(5, 12, 21, 32), pk8(5, 12, 21, 32),
                pk8(5, 12, 21, 32), 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b11, a0, b0, 1, 1, pk16(5, 12, 21, 32), pk8(5, 12, 21, 32),
                pk8(5, 12, 21, 32), 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'b00, ff, ff, 10, 1, pk16(64514, 64514, 64514, 64514),
                pk8(255, 255, 255, 255), pk8(2, 2, 2, 2), 1'b0, 1'b1, 1'b1};
    vecs[5] = '{2'b11, a0, b0, 1, 1, pk16(64514, 64514, 64514, 64514),
                pk8(255, 255, 255, 255), pk8(2, 2, 2, 2), 1'b1, 1'b1, 1'b1};
    vecs[6] = '{2'b01, ff, ff, 6, 1, pk16(510, 510, 510, 510),
                pk8(255, 255, 255, 255), pk8(254, 254, 254, 254), 1'b0, 1'b0, 1'b1};
    vecs[7] = '{2'b10, ff, ff, 6, 1, pk16(65025, 65025, 65025, 65025),
                pk8(255, 255, 255, 255), pk8(1, 1, 1, 1), 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    mode  = 2'b00;
    mat_a = '0;
    mat_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {res_a[62:0], busy_a | done_a | inv_a | ovf_a}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) run(vecs[v]);

    // Reset in the middle of a matrix product drops the partial result
    @(negedge clk);
    mode  = 2'b00;
    mat_a = a0;
    mat_b = b0;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("partial_elem0", 64'(res_a[15:0]), 64'd19);
    check("invalid_inst_before_reset", 64'(inv_i), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid_busy_done", 64'({busy_a, done_a, busy_w, done_w}), 64'd0);
    check("reset_mid_result", res_a, 64'd0);
    check("reset_mid_invalid_inst", 64'(inv_i), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run(vecs[0]);
    run(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
